vga_output_pipeline: RTL and testbench
======================================

// Module: vga_output_pipeline
// PURPOSE
// Parametrised VGA front end: generates the h/v timing, drives row/column to the pixel drawer,
// and aligns sync and blanking to a drawer with configurable latency.
// Adds frame-synchronous pattern modes for bring-up: drawer, colour bars and solid colour.
// Sits between the game-state drawer and the board VGA pins.
// One instance per display.
// PARAMETERS
// H_ACTIVE 640 visible pixels per line;  H_FP 16 front porch;  H_SYNC 96 sync width;  H_BP 48 back porch
// V_ACTIVE 480 visible lines;  V_FP 10;  V_SYNC 2;  V_BP 33 (all in lines)
// H_POL 0 / V_POL 0  sync active level (0 = active-low)
// COLOR_BITS 4  bits per colour channel
// PIXEL_LATENCY 1  drawer cycles from row/column to colour valid; legal range 0..7
// PORTS
// vga_clock      in   1             pixel clock
// reset          in   1             synchronous, active-high
// mode           in   2             0 = drawer, 1 = colour bars, 2 = solid, 3 = blank; sampled at frame start
// solid_rgb      in   3*COLOR_BITS  {r,g,b} used in mode 2; sampled with mode
// draw_red/green/blue in COLOR_BITS each  drawer colour, PIXEL_LATENCY cycles after row/column
// row            out  12            current v count to drawer (raw, includes blanking)
// column         out  12            current h count to drawer (raw, includes blanking)
// frame_start    out  1             one-cycle pulse when h=0,v=0 at counter stage
// hsync, vsync   out  1             delayed syncs at pins
// vga_red/green/blue out COLOR_BITS each  registered pin colours
// BEHAVIOUR
// H_TOTAL = sum of H_* params (800); V_TOTAL = sum of V_* params (525).
// Counters:
// - h increments each cycle and wraps H_TOTAL-1 -> 0.
// - v increments on the h wrap and wraps V_TOTAL-1 -> 0.
// - row = v and column = h, both registered.
// Stage-0 flags:
// - active = h<H_ACTIVE && v<V_ACTIVE.
// - hs_raw = h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
// - vs_raw = v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1].
// - Sync output level = raw ? POL : !POL.
// Delay line:
// - active, hs, vs and column[11:0] pass through a PIXEL_LATENCY-deep shift register.
// - With PIXEL_LATENCY=0 this is a wire.
// - A final output register drives the pins.
// - Total latency from row/column to pins = PIXEL_LATENCY+1 cycles.
// - hsync, vsync and colour stay mutually aligned.
// Mode latch:
// - mode and solid_rgb are captured only in the cycle frame_start=1.
// - The captured values govern the whole frame.
// - Mid-frame changes are ignored until the next frame.
// Colour select (delayed stage):
// - active=0 -> 0 on all channels, regardless of mode.
// - mode 0: draw_*.
// - mode 1: bar = column_d / (H_ACTIVE/8), clamped to 7.
//   Bar order: white, yellow, cyan, green, magenta, red, blue, black.
//   Each channel is either all-ones or 0.
// - mode 2: latched solid_rgb.
// - mode 3: 0.
// Reset (while asserted and on the first cycle after release):
// - h=v=0; row=column=0; frame_start=0.
// - Delay line cleared to inactive; hsync=!H_POL, vsync=!V_POL.
// - Colours 0; latched mode=0, solid_rgb=0.
// Reset release: the first edge after release begins line 0, pixel 0, and frame_start pulses for it.
// Reset mid-frame: same as above; no partial sync pulse survives, because the delay line is cleared.
// Wrap: the h and v wraps in the same cycle (h=H_TOTAL-1, v=V_TOTAL-1) go to 0,0 with frame_start.
// TESTING
// 1 Defaults, PIXEL_LATENCY=1, run 2 frames.
//   -> hsync low for 96 cycles per 800; vsync low for 2 lines (1600 cycles) per 525 lines.
//   -> frame_start period 420000 cycles.
// 2 mode=0, draw_* = column[3:0] delayed 1 cycle.
//   -> the pin colour at cycle t+2 equals the low bits of the column presented at t.
//   -> all colours are 0 when column>=640 or row>=480.
// 3 mode=1.
//   -> pins show white for columns 0-79, yellow for 80-159, and so on through black for 560-639.
//   -> exact boundaries are checked at 79/80 and 559/560.
// 4 Switch mode 0->2 with solid_rgb=12'hF00 at row 200.
//   -> output unchanged until the next frame_start, then 4'hF/0/0 over the full active area.
// 5 Assert reset for 3 cycles at h=700, v=490 (inside vsync).
//   -> vsync=1, hsync=1 and colours 0 during reset.
//   -> after release h counts from 0 and a fresh frame_start fires.
// 6 PIXEL_LATENCY=0 and PIXEL_LATENCY=7 builds rerun scenarios 1-2.
//   -> pin latency 1 and 8 cycles respectively; sync widths unchanged.

Source files
------------

// File: rtl/vga_output_pipeline.sv
// VGA front end: h/v timing, row/column to the drawer, sync and blanking delayed to
// match the drawer latency, and frame-synchronous bring-up pattern modes.
module vga_output_pipeline #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter bit H_POL         = 1'b0,
    parameter bit V_POL         = 1'b0,
    parameter int COLOR_BITS    = 4,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic                    vga_clock,
    input  logic                    reset,
    input  logic [1:0]              mode,
    input  logic [3*COLOR_BITS-1:0] solid_rgb,
    input  logic [COLOR_BITS-1:0]   draw_red,
    input  logic [COLOR_BITS-1:0]   draw_green,
    input  logic [COLOR_BITS-1:0]   draw_blue,
    output logic [11:0]             row,
    output logic [11:0]             column,
    output logic                    frame_start,
    output logic                    hsync,
    output logic                    vsync,
    output logic [COLOR_BITS-1:0]   vga_red,
    output logic [COLOR_BITS-1:0]   vga_green,
    output logic [COLOR_BITS-1:0]   vga_blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
    localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [11:0] BAR_W    = 12'(H_ACTIVE / 8);

    // Bar index -> {r,g,b} on/off: white, yellow, cyan, green, magenta, red, blue, black.
    function automatic logic [2:0] bar_mask(input logic [11:0] col);
        logic [11:0] bar;
        bar = col / BAR_W;
        if (bar > 12'd7)
            bar = 12'd7;
        return {~bar[1], ~bar[2], ~bar[0]};
    endfunction

    function automatic logic sync_level(input logic raw, input logic pol);
        return raw ? pol : ~pol;
    endfunction

    // Counter stage. running is low through reset and the first cycle after release,
    // so the restart pixel (0,0) is produced exactly once, together with frame_start.
    logic running;

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            running     <= 1'b0;
            column      <= '0;
            row         <= '0;
            frame_start <= 1'b0;
        end else if (!running) begin
            running     <= 1'b1;
            column      <= '0;
            row         <= '0;
            frame_start <= 1'b1;
        end else begin
            frame_start <= (column == H_LAST) && (row == V_LAST);
            if (column == H_LAST) begin
                column <= '0;
                row    <= (row == V_LAST) ? 12'd0 : row + 12'd1;
            end else begin
                column <= column + 12'd1;
            end
        end
    end

    // Stage 0: flags derived from the counters presented to the drawer.
    logic vld_p0, hs_p0, vs_p0;

    assign vld_p0 = running && (column < H_ACT) && (row < V_ACT);
    assign hs_p0  = running && (column >= HS_START) && (column <= HS_END);
    assign vs_p0  = running && (row >= VS_START) && (row <= VS_END);

    // Stage 1: flags and column delayed to line up with the drawer colour.
    logic        vld_p1, hs_p1, vs_p1;
    logic [11:0] col_p1;

    if (PIXEL_LATENCY == 0) begin : g_no_delay
        assign vld_p1 = vld_p0;
        assign hs_p1  = hs_p0;
        assign vs_p1  = vs_p0;
        assign col_p1 = column;
    end else begin : g_delay
        localparam int CW = 12 * PIXEL_LATENCY;

        logic [PIXEL_LATENCY-1:0] vld_sr, hs_sr, vs_sr;
        logic [CW-1:0]            col_sr;

        always_ff @(posedge vga_clock) begin
            if (reset) begin
                vld_sr <= '0;
                hs_sr  <= '0;
                vs_sr  <= '0;
            end else begin
                vld_sr <= PIXEL_LATENCY'({vld_sr, vld_p0});
                hs_sr  <= PIXEL_LATENCY'({hs_sr, hs_p0});
                vs_sr  <= PIXEL_LATENCY'({vs_sr, vs_p0});
            end
        end

        always_ff @(posedge vga_clock) begin
            col_sr <= CW'({col_sr, column});
        end

        assign vld_p1 = vld_sr[PIXEL_LATENCY-1];
        assign hs_p1  = hs_sr[PIXEL_LATENCY-1];
        assign vs_p1  = vs_sr[PIXEL_LATENCY-1];
        assign col_p1 = col_sr[CW-1 -: 12];
    end

    // Mode and solid colour held for the whole frame.
    logic [1:0]              mode_q;
    logic [3*COLOR_BITS-1:0] rgb_q;

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            mode_q <= 2'd0;
            rgb_q  <= '0;
        end else if (frame_start) begin
            mode_q <= mode;
            rgb_q  <= solid_rgb;
        end
    end

    // With no drawer latency pixel (0,0) is coloured in the frame_start cycle itself,
    // before the latch has caught the new mode, so it takes the inputs directly.
    logic [1:0]              mode_p1;
    logic [3*COLOR_BITS-1:0] rgb_p1;
    logic [2:0]              bars_p1;

    assign mode_p1 = (PIXEL_LATENCY == 0 && frame_start) ? mode : mode_q;
    assign rgb_p1  = (PIXEL_LATENCY == 0 && frame_start) ? solid_rgb : rgb_q;
    assign bars_p1 = bar_mask(col_p1);

    logic [COLOR_BITS-1:0] red_p1, green_p1, blue_p1;

    always_comb begin
        red_p1   = '0;
        green_p1 = '0;
        blue_p1  = '0;
        if (vld_p1) begin
            case (mode_p1)
                2'd0: begin
                    red_p1   = draw_red;
                    green_p1 = draw_green;
                    blue_p1  = draw_blue;
                end
                2'd1: begin
                    red_p1   = {COLOR_BITS{bars_p1[2]}};
                    green_p1 = {COLOR_BITS{bars_p1[1]}};
                    blue_p1  = {COLOR_BITS{bars_p1[0]}};
                end
                2'd2: {red_p1, green_p1, blue_p1} = rgb_p1;
                default: ;
            endcase
        end
    end

    // Stage 2: pin register.
    always_ff @(posedge vga_clock) begin
        if (reset) begin
            hsync     <= ~H_POL;
            vsync     <= ~V_POL;
            vga_red   <= '0;
            vga_green <= '0;
            vga_blue  <= '0;
        end else begin
            hsync     <= sync_level(hs_p1, H_POL);
            vsync     <= sync_level(vs_p1, V_POL);
            vga_red   <= red_p1;
            vga_green <= green_p1;
            vga_blue  <= blue_p1;
        end
    end

endmodule

// File: tb/tb_vga_output_pipeline.sv
// Bench for vga_output_pipeline: three builds (latency 1, 0, 7; mixed polarities) on a
// reduced raster, random drawer colours and mid-frame mode changes, one mid-frame reset.
module tb_vga_output_pipeline;

    localparam int HA = 16, HF = 2, HSW = 3, HB = 3;
    localparam int VA = 8, VF = 1, VSW = 2, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;
    localparam int FR = HT * VT;
    localparam int NCYC = 3600;
    localparam int INJ = 4 * FR + 9 * HT + 20;
    localparam int NI = 3;
    localparam int LAT [NI] = '{1, 0, 7};
    localparam bit HPOL [NI] = '{1'b0, 1'b1, 1'b0};
    localparam bit VPOL [NI] = '{1'b0, 1'b1, 1'b1};
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic        vga_clock = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mode = 2'd0;
    logic [11:0] solid_rgb = 12'h000;
    logic [3:0]  draw_red = 4'h0, draw_green = 4'h0, draw_blue = 4'h0;

    logic [11:0] row_o [NI];
    logic [11:0] column_o [NI];
    logic        fs_o [NI];
    logic        hs_o [NI];
    logic        vs_o [NI];
    logic [3:0]  r_o [NI];
    logic [3:0]  g_o [NI];
    logic [3:0]  b_o [NI];

    logic        rst_h [NCYC];
    logic [1:0]  mode_h [NCYC];
    logic [11:0] rgb_h [NCYC];
    logic [11:0] draw_h [NCYC];

    int n_checks = 0;
    int n_errors = 0;
    int cur_cycle = 0;
    int cur_inst = 0;

    initial forever #5 vga_clock = ~vga_clock;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        vga_output_pipeline #(
            .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
            .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
            .H_POL(HPOL[gi]), .V_POL(VPOL[gi]),
            .COLOR_BITS(4), .PIXEL_LATENCY(LAT[gi])
        ) u_dut (
            .vga_clock  (vga_clock),
            .reset      (reset),
            .mode       (mode),
            .solid_rgb  (solid_rgb),
            .draw_red   (draw_red),
            .draw_green (draw_green),
            .draw_blue  (draw_blue),
            .row        (row_o[gi]),
            .column     (column_o[gi]),
            .frame_start(fs_o[gi]),
            .hsync      (hs_o[gi]),
            .vsync      (vs_o[gi]),
            .vga_red    (r_o[gi]),
            .vga_green  (g_o[gi]),
            .vga_blue   (b_o[gi])
        );
    end

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s inst=%0d cycle=%0d: got %0h expected %0h",
                         tag, cur_inst, cur_cycle, obs, exp_v);
        end
    endtask

    // Reference: everything follows from the cycle count since the run began (rs).
    function automatic void expect_out(input int inst, input int k, input int rs,
                                       output int e_row, output int e_col, output int e_fs,
                                       output int e_hs, output int e_vs, output int e_rgb);
        int n, p, hp, vp, cap, bar;
        e_row = 0;
        e_col = 0;
        e_fs  = 0;
        e_hs  = HPOL[inst] ? 0 : 1;
        e_vs  = VPOL[inst] ? 0 : 1;
        e_rgb = 0;
        if (rs < 0) return;
        n = k - rs;
        e_row = (n / HT) % VT;
        e_col = n % HT;
        e_fs  = (n % FR == 0) ? 1 : 0;
        p = n - LAT[inst] - 1;
        if (p < 0) return;
        hp = p % HT;
        vp = (p / HT) % VT;
        if (hp >= HA + HF && hp < HA + HF + HSW) e_hs = HPOL[inst] ? 1 : 0;
        if (vp >= VA + VF && vp < VA + VF + VSW) e_vs = VPOL[inst] ? 1 : 0;
        if (hp < HA && vp < VA) begin
            cap = rs + (p / FR) * FR;
            case (mode_h[cap])
                2'd0: e_rgb = int'(draw_h[k-1]);
                2'd1: begin
                    bar = hp / (HA / 8);
                    if (bar > 7) bar = 7;
                    e_rgb = int'(BARS[bar]);
                end
                2'd2: e_rgb = int'(rgb_h[cap]);
                default: e_rgb = 0;
            endcase
        end
    endfunction

    initial begin
        int rs, rst_left, next_chg;
        bit injected;
        int e_row, e_col, e_fs, e_hs, e_vs, e_rgb;
        rs = -1;
        rst_left = 0;
        next_chg = 40;
        injected = 1'b0;
        for (int k = 0; k < NCYC; k++) begin
            @(posedge vga_clock);
            #1;
            if (k < 1) rs = -1;
            else if (rst_h[k-1]) rs = -1;
            else if (rs < 0) rs = k;

            if (!injected && rs >= 0 && (k - rs) == INJ) begin
                injected = 1'b1;
                rst_left = 3;
            end
            if (k < 4) begin
                reset = 1'b1;
            end else if (rst_left > 0) begin
                reset = 1'b1;
                rst_left--;
            end else begin
                reset = 1'b0;
            end

            if (k == next_chg) begin
                mode = mode + 2'd1;
                solid_rgb = 12'($urandom);
                next_chg = k + int'($urandom_range(150, 450));
            end
            {draw_red, draw_green, draw_blue} = 12'($urandom);

            rst_h[k]  = reset;
            mode_h[k] = mode;
            rgb_h[k]  = solid_rgb;
            draw_h[k] = {draw_red, draw_green, draw_blue};

            @(negedge vga_clock);
            cur_cycle = k;
            for (int i = 0; i < NI; i++) begin
                cur_inst = i;
                expect_out(i, k, rs, e_row, e_col, e_fs, e_hs, e_vs, e_rgb);
                check_val("row", int'(row_o[i]), e_row);
                check_val("column", int'(column_o[i]), e_col);
                check_val("frame_start", int'(fs_o[i]), e_fs);
                check_val("hsync", int'(hs_o[i]), e_hs);
                check_val("vsync", int'(vs_o[i]), e_vs);
                check_val("rgb", int'({r_o[i], g_o[i], b_o[i]}), e_rgb);
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
